snoop_bus_arbiter: RTL and testbench
====================================

// Module: snoop_bus_arbiter
// PURPOSE
//  Round-robin owner of the shared snooping bus between NUM_CACHES private L1/L2 caches.
//  - Accepts one bus action per cache: GetS, GetX, Inv or PutX.
//  - Grants the bus to exactly one cache at a time.
//  - Broadcasts the granted action as per-cache *_obs strobes and collects share responses.
//  - Sequences the main-memory read/write and signals completion back to the requester.
// PARAMETERS
//  NUM_CACHES  4   number of private cache hierarchies on the bus (power of 2, >=2)
//  ADDR_W      32  block address width carried on the bus
// PORTS
//  clk        in   1                  system clock
//  reset      in   1                  asynchronous, active-high reset
//  gets_BA    in   NUM_CACHES         per-cache GetS request, held until done
//  getx_BA    in   NUM_CACHES         per-cache GetX request, held until done
//  inv_BA     in   NUM_CACHES         per-cache Inv request, held until done
//  putx_BA    in   NUM_CACHES         per-cache PutX (writeback) request, held until done
//  req_addr   in   NUM_CACHES*ADDR_W  per-cache request address; slice i belongs to cache i
//  share_in   in   NUM_CACHES         per-cache share reply, sampled only in SNOOP
//  mem_ready  in   1                  memory has completed the current rd/wr
//  grant      out  NUM_CACHES         one-hot bus owner
//  bus_addr   out  ADDR_W             latched address of the granted request
//  gets_obs   out  NUM_CACHES         GetS broadcast to non-owner caches
//  getx_obs   out  NUM_CACHES         GetX broadcast to non-owner caches
//  inv_obs    out  NUM_CACHES         Inv broadcast to non-owner caches
//  shared     out  1                  line held by a peer; valid while done is high
//  mem_rd     out  1                  memory read request
//  mem_wr     out  1                  memory write (PutX) request
//  done       out  NUM_CACHES         one-cycle completion pulse to the owner
//  busy       out  1                  state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; rr_ptr=0; every output 0. Reset is asynchronous and takes effect mid-transaction.
//  - Per-cache op priority when several bits are set: PutX > GetX > Inv > GetS.
//    - Only the winning op is served; the other ops stay pending.
//  - FSM IDLE -> BCAST -> SNOOP -> {MEM | DONE}; MEM -> DONE; DONE -> IDLE.
//  - IDLE: any request bit set at a clock edge triggers the grant.
//    - Winner = first requester at or after rr_ptr, wrapping modulo NUM_CACHES.
//    - Winner index, op and addr slice are registered; grant is onehot(winner); go to BCAST.
//  - BCAST, one cycle: the op's *_obs is asserted to every cache except the owner.
//    - PutX asserts no *_obs.
//  - SNOOP, one cycle: shared_q <= |(share_in & ~grant).
//    - GetS with shared_q=1 -> DONE; the peer supplies the data and memory is skipped.
//    - Inv -> DONE.
//    - Otherwise -> MEM.
//  - MEM: assert mem_rd (GetS/GetX) or mem_wr (PutX), held level until mem_ready=1, then go to DONE.
//    - mem_ready outside MEM is ignored.
//  - DONE, one cycle: done[owner]=1; shared=shared_q (0 for non-GetS ops).
//    - rr_ptr <= (owner+1) mod NUM_CACHES; grant, bus_addr and shared clear on the exit to IDLE.
//  - Latency: request seen at edge 0 -> grant from cycle 1.
//    - Without MEM, done is in cycle 3.
//    - With MEM, done comes 1 cycle after the cycle in which mem_ready is seen.
//    - Minimum spacing between successive grants is 4 cycles.
//  - Requests are not preempted. A request dropped after grant is ignored and the transaction completes.
//  - A request that appears while busy waits for the return to IDLE.
//  - rr_ptr width = $clog2(NUM_CACHES); wraps naturally because NUM_CACHES is a power of 2.
// STRUCTURE
//  - cacheLinePackage gains: typedef enum logic [2:0] {BUS_NONE, BUS_GETS, BUS_GETX, BUS_INV, BUS_PUTX} bus_op_t;
//  - Local arb_state_t enum {IDLE, BCAST, SNOOP, MEM, DONE} lives in this module.
//  - Sub-module rr_arbiter #(NUM_CACHES): combinational (req vector, rr_ptr) -> one-hot grant + index.
//  - All outputs are registered; *_obs/mem_rd/mem_wr are decoded from registered state plus op.
// TESTING
//  1. Cache1 GetS addr 0x100, share_in=0, mem_ready in 3rd MEM cycle ->
//     grant=0010 from cycle 1; gets_obs=1101 in cycle 1; mem_rd cycles 3-5; done=0010 cycle 6; shared=0.
//  2. Cache2 GetS, share_in[0]=1 during SNOOP ->
//     mem_rd never asserted; done=0100 at cycle 3 with shared=1.
//  3. After reset all 4 caches hold GetS, mem_ready tied 1 ->
//     grants in order 0,1,2,3,0; no grant gap below 4 cycles.
//  4. Cache3 asserts putx_BA and gets_BA together ->
//     PutX served first; no *_obs asserted; mem_wr=1; GetS granted in a later transaction.
//  5. Cache0 Inv addr 0x40 ->
//     inv_obs=1110 in cycle 1; no mem_rd/mem_wr; done=0001 at cycle 3.
//  6. Reset asserted mid-MEM ->
//     all outputs 0 immediately; state IDLE; next grant goes to cache 0 first.

Source files
------------

// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared types for the snooping-bus arbiter: bus operation encoding and
// the per-cache priority rule that picks one op out of several pending ones.
package snoop_bus_arbiter_pkg;

    typedef enum logic [2:0] {BUS_NONE, BUS_GETS, BUS_GETX, BUS_INV, BUS_PUTX} bus_op_t;

    // A writeback must drain before the same cache can fetch again, hence PutX first.
    function automatic bus_op_t pick_op(input logic gets, input logic getx,
                                        input logic inv, input logic putx);
        if (putx)      return BUS_PUTX;
        else if (getx) return BUS_GETX;
        else if (inv)  return BUS_INV;
        else if (gets) return BUS_GETS;
        else           return BUS_NONE;
    endfunction

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// Cache-facing side of the snooping bus: requests and addresses in, grant,
// broadcast strobes and memory handshake out.
interface snoop_bus_arbiter_if #(
    parameter int NUM_CACHES = 4,
    parameter int ADDR_W     = 32
);
    logic [NUM_CACHES-1:0]        gets_BA;
    logic [NUM_CACHES-1:0]        getx_BA;
    logic [NUM_CACHES-1:0]        inv_BA;
    logic [NUM_CACHES-1:0]        putx_BA;
    logic [NUM_CACHES*ADDR_W-1:0] req_addr;
    logic [NUM_CACHES-1:0]        share_in;
    logic                         mem_ready;

    logic [NUM_CACHES-1:0]        grant;
    logic [ADDR_W-1:0]            bus_addr;
    logic [NUM_CACHES-1:0]        gets_obs;
    logic [NUM_CACHES-1:0]        getx_obs;
    logic [NUM_CACHES-1:0]        inv_obs;
    logic                         shared;
    logic                         mem_rd;
    logic                         mem_wr;
    logic [NUM_CACHES-1:0]        done;
    logic                         busy;

    modport master (
        input  gets_BA, getx_BA, inv_BA, putx_BA, req_addr, share_in, mem_ready,
        output grant, bus_addr, gets_obs, getx_obs, inv_obs, shared,
               mem_rd, mem_wr, done, busy
    );

    modport slave (
        output gets_BA, getx_BA, inv_BA, putx_BA, req_addr, share_in, mem_ready,
        input  grant, bus_addr, gets_obs, getx_obs, inv_obs, shared,
               mem_rd, mem_wr, done, busy
    );

endinterface

// File: rtl/snoop_bus_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping around the power-of-two requester count.
module rr_arbiter #(
    parameter int NUM_CACHES = 4
) (
    input  logic [NUM_CACHES-1:0]         req_i,
    input  logic [$clog2(NUM_CACHES)-1:0] ptr_i,
    output logic [NUM_CACHES-1:0]         grant_o,
    output logic [$clog2(NUM_CACHES)-1:0] idx_o,
    output logic                          valid_o
);
    localparam int PW = $clog2(NUM_CACHES);

    logic [PW-1:0] cand;

    // Scan farthest-first so the requester nearest ptr_i is the last one written.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = NUM_CACHES - 1; k >= 0; k--) begin
            cand = ptr_i + PW'(k);
            if (req_i[cand]) begin
                grant_o       = '0;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner of the shared snooping bus: grants one cache, broadcasts
// its op to the peers, collects share replies and sequences main memory.
module snoop_bus_arbiter
    import snoop_bus_arbiter_pkg::*;
#(
    parameter int NUM_CACHES = 4,
    parameter int ADDR_W     = 32
) (
    input logic                 clk,
    input logic                 reset,
    snoop_bus_arbiter_if.master bus
);
    localparam int PW = $clog2(NUM_CACHES);

    typedef enum logic [2:0] {IDLE, BCAST, SNOOP, MEM, DONE} arb_state_t;

    arb_state_t            state_q;
    bus_op_t               op_q;
    logic [PW-1:0]         owner_q;
    logic [PW-1:0]         rr_ptr_q;
    logic [NUM_CACHES-1:0] grant_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  shared_q;

    logic [NUM_CACHES-1:0] reqAny;
    logic [NUM_CACHES-1:0] winnerGrant;
    logic [PW-1:0]         winnerIdx;
    logic                  winnerValid;
    bus_op_t               winnerOp;
    logic [ADDR_W-1:0]     winnerAddr;
    logic                  peerShared;

    assign reqAny = bus.gets_BA | bus.getx_BA | bus.inv_BA | bus.putx_BA;

    rr_arbiter #(.NUM_CACHES(NUM_CACHES)) u_rr (
        .req_i   (reqAny),
        .ptr_i   (rr_ptr_q),
        .grant_o (winnerGrant),
        .idx_o   (winnerIdx),
        .valid_o (winnerValid)
    );

    assign winnerOp   = pick_op(bus.gets_BA[winnerIdx], bus.getx_BA[winnerIdx],
                                bus.inv_BA[winnerIdx],  bus.putx_BA[winnerIdx]);
    assign winnerAddr = bus.req_addr[int'(winnerIdx)*ADDR_W +: ADDR_W];
    assign peerShared = |(bus.share_in & ~grant_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= BUS_NONE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            shared_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (winnerValid) begin
                        state_q <= BCAST;
                        op_q    <= winnerOp;
                        owner_q <= winnerIdx;
                        grant_q <= winnerGrant;
                        addr_q  <= winnerAddr;
                    end
                end
                BCAST: state_q <= SNOOP;
                // A sharing peer supplies GetS data, so memory is skipped for it.
                SNOOP: begin
                    shared_q <= (op_q == BUS_GETS) && peerShared;
                    if (op_q == BUS_INV || (op_q == BUS_GETS && peerShared))
                        state_q <= DONE;
                    else
                        state_q <= MEM;
                end
                MEM: begin
                    if (bus.mem_ready)
                        state_q <= DONE;
                end
                DONE: begin
                    state_q  <= IDLE;
                    op_q     <= BUS_NONE;
                    rr_ptr_q <= owner_q + 1'b1;
                    grant_q  <= '0;
                    addr_q   <= '0;
                    shared_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.bus_addr = addr_q;
    assign bus.gets_obs = (state_q == BCAST && op_q == BUS_GETS) ? ~grant_q : '0;
    assign bus.getx_obs = (state_q == BCAST && op_q == BUS_GETX) ? ~grant_q : '0;
    assign bus.inv_obs  = (state_q == BCAST && op_q == BUS_INV)  ? ~grant_q : '0;
    assign bus.mem_rd   = (state_q == MEM) && (op_q == BUS_GETS || op_q == BUS_GETX);
    assign bus.mem_wr   = (state_q == MEM) && (op_q == BUS_PUTX);
    assign bus.done     = (state_q == DONE) ? grant_q : '0;
    assign bus.shared   = (state_q == DONE) && shared_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter: directed scenarios plus a
// randomized run against a transaction-level model of the bus protocol.
module tb_snoop_bus_arbiter;
    import snoop_bus_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int OW = 5 * N + AW + 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [3:0]    modelPend [N];
    logic [AW-1:0] modelAddr [N];

    always #5 clk = ~clk;

    snoop_bus_arbiter_if #(.NUM_CACHES(N), .ADDR_W(AW)) bus ();

    snoop_bus_arbiter #(.NUM_CACHES(N), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [OW-1:0] outVec();
        return {bus.grant, bus.bus_addr, bus.gets_obs, bus.getx_obs, bus.inv_obs,
                bus.done, bus.shared, bus.mem_rd, bus.mem_wr, bus.busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.gets_BA   = '0;
        bus.getx_BA   = '0;
        bus.inv_BA    = '0;
        bus.putx_BA   = '0;
        bus.req_addr  = '0;
        bus.share_in  = '0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        clearInputs();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Model request bits: 0 GetS, 1 GetX, 2 Inv, 3 PutX.
    task automatic driveModelReqs();
        for (int c = 0; c < N; c++) begin
            bus.gets_BA[c] = modelPend[c][0];
            bus.getx_BA[c] = modelPend[c][1];
            bus.inv_BA[c]  = modelPend[c][2];
            bus.putx_BA[c] = modelPend[c][3];
            bus.req_addr[c*AW +: AW] = modelAddr[c];
        end
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (outVec() !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want 0", outVec());
        end
    endtask

    task automatic test_gets_mem();
        clearInputs();
        bus.req_addr[1*AW +: AW] = 32'h100;
        bus.gets_BA = 4'b0010;
        tick();
        checks++;
        if (bus.grant !== 4'b0010) begin
            errors++; $display("[TB] FAIL t1_grant got %b want 0010", bus.grant);
        end
        checks++;
        if (bus.gets_obs !== 4'b1101) begin
            errors++; $display("[TB] FAIL t1_gets_obs got %b want 1101", bus.gets_obs);
        end
        checks++;
        if (bus.bus_addr !== 32'h100) begin
            errors++; $display("[TB] FAIL t1_bus_addr got %h want 100", bus.bus_addr);
        end
        tick();
        checks++;
        if (bus.mem_rd !== 1'b0 || bus.gets_obs !== 4'b0000) begin
            errors++; $display("[TB] FAIL t1_snoop got rd=%b obs=%b want 0/0000", bus.mem_rd, bus.gets_obs);
        end
        for (int c = 3; c <= 5; c++) begin
            tick();
            if (c == 5) bus.mem_ready = 1'b1;
            checks++;
            if (bus.mem_rd !== 1'b1 || bus.done !== 4'b0000) begin
                errors++; $display("[TB] FAIL t1_mem_rd cycle %0d got rd=%b done=%b want 1/0000", c, bus.mem_rd, bus.done);
            end
        end
        tick();
        bus.mem_ready = 1'b0;
        bus.gets_BA   = '0;
        checks++;
        if (bus.done !== 4'b0010 || bus.shared !== 1'b0 || bus.mem_rd !== 1'b0) begin
            errors++; $display("[TB] FAIL t1_done got done=%b shared=%b rd=%b want 0010/0/0", bus.done, bus.shared, bus.mem_rd);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.grant !== 4'b0000 || bus.bus_addr !== '0) begin
            errors++; $display("[TB] FAIL t1_idle got busy=%b grant=%b addr=%h want 0", bus.busy, bus.grant, bus.bus_addr);
        end
    endtask

    task automatic test_gets_shared();
        clearInputs();
        bus.gets_BA  = 4'b0100;
        bus.share_in = 4'b0001;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (bus.mem_rd !== 1'b0 || bus.grant !== 4'b0100) begin
                errors++; $display("[TB] FAIL t2_cycle%0d got rd=%b grant=%b want 0/0100", c, bus.mem_rd, bus.grant);
            end
        end
        checks++;
        if (bus.done !== 4'b0100 || bus.shared !== 1'b1) begin
            errors++; $display("[TB] FAIL t2_done got done=%b shared=%b want 0100/1", bus.done, bus.shared);
        end
        clearInputs();
        tick();
    endtask

    task automatic test_round_robin();
        int owners[$];
        int starts[$];
        logic [N-1:0] prev;
        doReset();
        bus.gets_BA   = '1;
        bus.mem_ready = 1'b1;
        prev = '0;
        for (int cyc = 1; cyc <= 80 && owners.size() < 5; cyc++) begin
            tick();
            if (bus.grant !== '0 && prev === '0) begin
                int idx;
                idx = -1;
                for (int i = 0; i < N; i++) if (bus.grant[i]) idx = i;
                if (!$onehot(bus.grant)) idx = -1;
                owners.push_back(idx);
                starts.push_back(cyc);
            end
            prev = bus.grant;
        end
        checks++;
        if (owners.size() != 5) begin
            errors++; $display("[TB] FAIL t3_grant_count got %0d want 5", owners.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (owners[i] != i % N) begin
                    errors++; $display("[TB] FAIL t3_order grant %0d got cache %0d want %0d", i, owners[i], i % N);
                end
                if (i > 0) begin
                    checks++;
                    if (starts[i] - starts[i-1] < 4) begin
                        errors++; $display("[TB] FAIL t3_gap got %0d want >=4", starts[i] - starts[i-1]);
                    end
                end
            end
        end
        bus.gets_BA = '0;
        for (int k = 0; k < 20 && bus.busy === 1'b1; k++) tick();
        clearInputs();
        tick();
    endtask

    task automatic test_priority();
        bit seen;
        clearInputs();
        bus.putx_BA = 4'b1000;
        bus.gets_BA = 4'b1000;
        bus.req_addr[3*AW +: AW] = 32'hABC0;
        tick();
        checks++;
        if (bus.grant !== 4'b1000 || (bus.gets_obs | bus.getx_obs | bus.inv_obs) !== 4'b0000) begin
            errors++; $display("[TB] FAIL t4_bcast got grant=%b obs=%b want 1000/0000", bus.grant, bus.gets_obs | bus.getx_obs | bus.inv_obs);
        end
        tick();
        tick();
        bus.mem_ready = 1'b1;
        checks++;
        if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0) begin
            errors++; $display("[TB] FAIL t4_mem got wr=%b rd=%b want 1/0", bus.mem_wr, bus.mem_rd);
        end
        tick();
        bus.mem_ready = 1'b0;
        bus.putx_BA   = '0;
        checks++;
        if (bus.done !== 4'b1000 || bus.shared !== 1'b0) begin
            errors++; $display("[TB] FAIL t4_done got done=%b shared=%b want 1000/0", bus.done, bus.shared);
        end
        tick();
        tick();
        checks++;
        if (bus.grant !== 4'b1000 || bus.gets_obs !== 4'b0111) begin
            errors++; $display("[TB] FAIL t4_gets_later got grant=%b obs=%b want 1000/0111", bus.grant, bus.gets_obs);
        end
        bus.mem_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (bus.done === 4'b1000) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("[TB] FAIL t4_gets_done got none want done=1000 within 10 cycles");
        end
        clearInputs();
        tick();
    endtask

    task automatic test_inv();
        clearInputs();
        bus.inv_BA = 4'b0001;
        bus.req_addr[0 +: AW] = 32'h40;
        bus.mem_ready = 1'b1;
        tick();
        checks++;
        if (bus.inv_obs !== 4'b1110 || bus.bus_addr !== 32'h40) begin
            errors++; $display("[TB] FAIL t5_bcast got obs=%b addr=%h want 1110/40", bus.inv_obs, bus.bus_addr);
        end
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) tick();
            checks++;
            if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin
                errors++; $display("[TB] FAIL t5_nomem cycle %0d got rd=%b wr=%b want 0/0", c, bus.mem_rd, bus.mem_wr);
            end
        end
        checks++;
        if (bus.done !== 4'b0001) begin
            errors++; $display("[TB] FAIL t5_done got %b want 0001", bus.done);
        end
        clearInputs();
        tick();
    endtask

    task automatic test_reset_mid_mem();
        bit seen;
        clearInputs();
        bus.getx_BA = 4'b0100;
        tick();
        tick();
        tick();
        checks++;
        if (bus.mem_rd !== 1'b1) begin
            errors++; $display("[TB] FAIL t6_in_mem got rd=%b want 1", bus.mem_rd);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (outVec() !== '0) begin
            errors++; $display("[TB] FAIL t6_async_reset got %h want 0", outVec());
        end
        clearInputs();
        tick();
        reset = 1'b0;
        bus.gets_BA = 4'b1001;
        bus.mem_ready = 1'b1;
        tick();
        checks++;
        if (bus.grant !== 4'b0001) begin
            errors++; $display("[TB] FAIL t6_first_grant got %b want 0001", bus.grant);
        end
        bus.gets_BA = '0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (bus.busy === 1'b0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("[TB] FAIL t6_complete got busy=1 want idle within 10 cycles");
        end
        clearInputs();
    endtask

    task automatic test_random();
        int            ptr;
        int            w;
        int            lat;
        int            opBit;
        bus_op_t       op;
        logic [N-1:0]  ownerMask;
        logic [N-1:0]  share;
        logic          peer;
        logic          needMem;
        doReset();
        ptr = 0;
        for (int c = 0; c < N; c++) begin
            modelPend[c] = '0;
            modelAddr[c] = '0;
        end
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < N; c++) begin
                if (modelPend[c] == '0 && $urandom_range(0, 2) == 0) begin
                    modelPend[c] = 4'($urandom_range(1, 15));
                    modelAddr[c] = $urandom & 32'hFFFF_FFC0;
                end
            end
            if (modelPend[0] == '0 && modelPend[1] == '0 && modelPend[2] == '0 && modelPend[3] == '0) begin
                w = $urandom_range(0, N - 1);
                modelPend[w] = 4'b0001 << $urandom_range(0, 3);
                modelAddr[w] = $urandom & 32'hFFFF_FFC0;
            end
            driveModelReqs();
            share = 4'($urandom_range(0, 15));
            bus.share_in = share;

            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && modelPend[(ptr + k) % N] != '0) w = (ptr + k) % N;
            if      (modelPend[w][3]) begin op = BUS_PUTX; opBit = 3; end
            else if (modelPend[w][1]) begin op = BUS_GETX; opBit = 1; end
            else if (modelPend[w][2]) begin op = BUS_INV;  opBit = 2; end
            else                      begin op = BUS_GETS; opBit = 0; end
            ownerMask = 4'b0001 << w;
            peer      = |(share & ~ownerMask);
            needMem   = (op == BUS_PUTX) || (op == BUS_GETX) || (op == BUS_GETS && !peer);
            lat       = $urandom_range(1, 3);

            tick();
            checks++;
            if (bus.grant !== ownerMask || bus.bus_addr !== modelAddr[w]) begin
                errors++; $display("[TB] FAIL rnd%0d_grant got %b/%h want %b/%h", t, bus.grant, bus.bus_addr, ownerMask, modelAddr[w]);
            end
            checks++;
            if (bus.gets_obs !== (op == BUS_GETS ? ~ownerMask : 4'b0000) ||
                bus.getx_obs !== (op == BUS_GETX ? ~ownerMask : 4'b0000) ||
                bus.inv_obs  !== (op == BUS_INV  ? ~ownerMask : 4'b0000)) begin
                errors++; $display("[TB] FAIL rnd%0d_obs got %b/%b/%b op %s owner %0d", t, bus.gets_obs, bus.getx_obs, bus.inv_obs, op.name(), w);
            end
            if ($urandom_range(0, 3) == 0) begin
                modelPend[w][opBit] = 1'b0;
                driveModelReqs();
            end
            bus.mem_ready = 1'($urandom_range(0, 1));

            tick();
            bus.mem_ready = 1'($urandom_range(0, 1));
            checks++;
            if (bus.grant !== ownerMask || bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0 ||
                (bus.gets_obs | bus.getx_obs | bus.inv_obs) !== 4'b0000 || bus.done !== 4'b0000) begin
                errors++; $display("[TB] FAIL rnd%0d_snoop got grant=%b rd=%b wr=%b done=%b", t, bus.grant, bus.mem_rd, bus.mem_wr, bus.done);
            end

            if (needMem) begin
                for (int k = 1; k <= lat; k++) begin
                    tick();
                    bus.mem_ready = (k == lat);
                    checks++;
                    if (bus.mem_rd !== (op != BUS_PUTX) || bus.mem_wr !== (op == BUS_PUTX) || bus.done !== 4'b0000) begin
                        errors++; $display("[TB] FAIL rnd%0d_mem got rd=%b wr=%b done=%b op %s", t, bus.mem_rd, bus.mem_wr, bus.done, op.name());
                    end
                end
            end

            tick();
            bus.mem_ready = 1'b0;
            checks++;
            if (bus.done !== ownerMask || bus.shared !== (op == BUS_GETS && peer) || bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin
                errors++; $display("[TB] FAIL rnd%0d_done got done=%b shared=%b want %b/%b", t, bus.done, bus.shared, ownerMask, (op == BUS_GETS && peer));
            end
            modelPend[w][opBit] = 1'b0;
            driveModelReqs();
            ptr = (w + 1) % N;

            tick();
            checks++;
            if (bus.busy !== 1'b0 || bus.grant !== 4'b0000 || bus.done !== 4'b0000) begin
                errors++; $display("[TB] FAIL rnd%0d_idle got busy=%b grant=%b done=%b want 0", t, bus.busy, bus.grant, bus.done);
            end
        end
        clearInputs();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        test_reset();
        test_gets_mem();
        test_gets_shared();
        test_round_robin();
        test_priority();
        test_inv();
        test_reset_mid_mem();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
